// File: rtl/ecc_pkg.sv
// ecc_pkg: shared states, default width, latency formula and mode encoding for ecc_point_unit
package ecc_pkg;
  localparam int W_DEF = 4;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_DBL = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_CHK, S_NUM, S_INV, S_LAM, S_RX, S_RY, S_DONE} state_t;
  function automatic int gen_latency(input int w);
    return 2 + (2 * w + 4) * (w + 1);
  endfunction
endpackage

// File: rtl/ecc_point_unit_if.sv
// ecc_point_unit_if: request/result bus between the scalar-multiplication core (master) and ecc_point_unit (slave)
interface ecc_point_unit_if import ecc_pkg::*; #(parameter int W = W_DEF);
  logic i_start, i_dbl, i_p_inf, i_q_inf, o_r_inf, o_busy, o_done;
  logic [W-1:0] i_a, i_prime, i_px, i_py, i_qx, i_qy, o_rx, o_ry;
  modport master(output i_start, i_dbl, i_p_inf, i_q_inf, i_a, i_prime, i_px, i_py, i_qx, i_qy,
                 input o_rx, o_ry, o_r_inf, o_busy, o_done);
  modport slave(input i_start, i_dbl, i_p_inf, i_q_inf, i_a, i_prime, i_px, i_py, i_qx, i_qy,
                output o_rx, o_ry, o_r_inf, o_busy, o_done);
endinterface

// File: rtl/mod_mul.sv
// mod_mul: interleaved MSB-first shift-add modular multiplier, 1 load + W iteration cycles, done/res valid in the last iteration cycle
module mod_mul #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] a_r, b_r, acc;
  logic [CW-1:0] cnt;
  logic [W:0] d, d1, s, s1;
  always_comb begin
    d = {acc, 1'b0};
    d1 = d >= {1'b0, p} ? d - {1'b0, p} : d;
    s = d1 + (b_r[W-1] ? {1'b0, a_r} : '0);
    s1 = s >= {1'b0, p} ? s - {1'b0, p} : s;
  end
  assign res = W'(s1);
  assign busy = cnt != '0;
  assign done = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      a_r <= a;
      b_r <= b;
      cnt <= CW'(W);
    end else if (busy) begin
      acc <= res;
      b_r <= b_r << 1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/ecc_point_unit.sv
// ecc_point_unit: iterative GF(p) short-Weierstrass point add/double; define ECC_PU_CONST_TIME_EN for constant-time special cases
module ecc_point_unit import ecc_pkg::*; #(parameter int W = W_DEF) (
  input logic i_clk,
  input logic i_rst,
  ecc_point_unit_if.slave bus
);
  localparam int BW = $clog2(W);
  state_t state, nxt;
  logic dbl, pi, qi, ph, sp, sp_inf, mul_go, mul_busy, mul_done, inf_o;
  logic [BW-1:0] bit_i;
  logic [W-1:0] pr, ar, px, py, qx, qy, num, den, inv, lam, rx, e, sp_x, sp_y, ma, mb, mr, rx_o, ry_o;
`ifdef ECC_PU_CONST_TIME_EN
  logic spr, spr_inf;
  logic [W-1:0] spr_x, spr_y;
`endif
  function automatic logic [W-1:0] fadd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s >= {1'b0, pr} ? W'(s - {1'b0, pr}) : W'(s);
  endfunction
  function automatic logic [W-1:0] fsub(input logic [W-1:0] x, input logic [W-1:0] y);
    return x >= y ? x - y : x - y + pr;
  endfunction
  assign e = pr - W'(2);
  always_comb begin
    sp = 1'b0;
    sp_inf = 1'b0;
    sp_x = '0;
    sp_y = '0;
    if (dbl == MODE_ADD && pi) begin
      sp = 1'b1;
      sp_inf = qi;
      sp_x = qi ? '0 : qx;
      sp_y = qi ? '0 : qy;
    end else if (dbl == MODE_ADD && qi) begin
      sp = 1'b1;
      sp_x = px;
      sp_y = py;
    end else if (dbl == MODE_ADD && px == qx && py != qy) begin
      sp = 1'b1;
      sp_inf = 1'b1;
    end else if ((dbl == MODE_DBL || px == qx) && (pi || py == '0)) begin
      sp = 1'b1;
      sp_inf = 1'b1;
    end
  end
  assign ma = state == S_NUM ? (dbl ? px : fsub(qy, py)) : state == S_INV ? inv : state == S_LAM ? num : lam;
  assign mb = state == S_NUM ? (dbl ? px : W'(1)) : state == S_INV ? (ph ? den : inv) :
              state == S_LAM ? inv : state == S_RX ? lam : fsub(px, rx);
  assign mul_go = (state inside {S_NUM, S_INV, S_LAM, S_RX, S_RY}) && !mul_busy;
  mod_mul #(.W(W)) u_mul (
    .clk(i_clk), .rst(i_rst), .start(mul_go), .a(ma), .b(mb), .p(pr),
    .busy(mul_busy), .done(mul_done), .res(mr)
  );
  always_ff @(posedge i_clk) begin
    state <= i_rst ? S_IDLE : nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = bus.i_start ? S_CHK : S_IDLE;
`ifdef ECC_PU_CONST_TIME_EN
      S_CHK: nxt = S_NUM;
`else
      S_CHK: nxt = sp ? S_DONE : S_NUM;
`endif
      S_NUM: nxt = mul_done ? S_INV : S_NUM;
      S_INV: nxt = (mul_done && ph && bit_i == '0) ? S_LAM : S_INV;
      S_LAM: nxt = mul_done ? S_RX : S_LAM;
      S_RX: nxt = mul_done ? S_RY : S_RX;
      S_RY: nxt = mul_done ? S_DONE : S_RY;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_o <= '0;
      ry_o <= '0;
      inf_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.i_start) begin
          dbl <= bus.i_dbl;
          pi <= bus.i_p_inf;
          qi <= bus.i_q_inf;
          ar <= bus.i_a;
          pr <= bus.i_prime;
          px <= bus.i_px;
          py <= bus.i_py;
          qx <= bus.i_qx;
          qy <= bus.i_qy;
        end
        S_CHK: begin
          dbl <= dbl | (px == qx);
`ifdef ECC_PU_CONST_TIME_EN
          spr <= sp;
          spr_inf <= sp_inf;
          spr_x <= sp_x;
          spr_y <= sp_y;
`else
          if (sp) begin
            rx_o <= sp_x;
            ry_o <= sp_y;
            inf_o <= sp_inf;
          end
`endif
        end
        S_NUM: if (mul_done) begin
          num <= dbl ? fadd(fadd(fadd(mr, mr), mr), ar) : mr;
          den <= dbl ? fadd(py, py) : fsub(qx, px);
          inv <= W'(1);
          bit_i <= BW'(W - 1);
          ph <= 1'b0;
        end
        S_INV: if (mul_done) begin
          if (!ph || e[bit_i]) inv <= mr;
          if (ph) bit_i <= bit_i - 1'b1;
          ph <= !ph;
        end
        S_LAM: if (mul_done) lam <= mr;
        S_RX: if (mul_done) rx <= fsub(fsub(mr, px), dbl ? px : qx);
        S_RY: if (mul_done) begin
`ifdef ECC_PU_CONST_TIME_EN
          rx_o <= spr ? spr_x : rx;
          ry_o <= spr ? spr_y : fsub(mr, py);
          inf_o <= spr_inf;
`else
          rx_o <= rx;
          ry_o <= fsub(mr, py);
          inf_o <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end
  assign bus.o_rx = rx_o;
  assign bus.o_ry = ry_o;
  assign bus.o_r_inf = inf_o;
  assign bus.o_busy = state != S_IDLE && state != S_DONE;
  assign bus.o_done = state == S_DONE;
endmodule

// File: doc/ecc_point_unit.md
# ecc_point_unit

- Iterative elliptic-curve point arithmetic unit over GF(p), short Weierstrass form y² = x³ + a·x + b.
- Computes R = P + Q (add) or R = 2P (double), with point-at-infinity handling.
- Sits directly below the scalar-multiplication core: the core issues one add or double per step on `i_start`, then consumes `o_rx`/`o_ry`/`o_r_inf` on `o_done`.
- Field width matches the core's 4-bit datapath by default.

## Interface

**Parameters**
- `W`, default 4: field element width; `i_prime` < 2^W.

**Ports**
- `i_clk`  in  1: clock; single clock domain.
- `i_rst`  in  1: synchronous reset, active-high.
- `i_start`  in  1: request; sampled only when idle.
- `i_dbl`  in  1: 1 = compute 2P (Q ignored); 0 = compute P+Q.
- `i_a`  in  W: curve coefficient a.
- `i_prime`  in  W: field modulus p.
- `i_px`, `i_py`  in  W each: P coordinates.
- `i_qx`, `i_qy`  in  W each: Q coordinates.
- `i_p_inf`, `i_q_inf`  in  1 each: P, Q is the point at infinity.
- `o_rx`, `o_ry`  out  W each: result coordinates; 0 when `o_r_inf`.
- `o_r_inf`  out  1: result is the point at infinity.
- `o_busy`  out  1: operation in progress.
- `o_done`  out  1: one-cycle pulse; result valid from this cycle.

## Operation

- Preconditions: p odd prime, 3 ≤ p < 2^W; all coordinates and a < p. Results are unspecified otherwise; no error is flagged.
- All inputs are captured into registers on the accepted start. Input changes after that have no effect.
- State machine: IDLE → CHK → NUM → INV → LAM → RX → RY → DONE → IDLE.
- **CHK** resolves special cases, in priority order:
  - Add mode:
    - P inf → R = Q (including `q_inf`).
    - Q inf → R = P.
    - px = qx and py ≠ qy → R = inf.
    - px = qx and py = qy → proceed as double.
  - Double mode:
    - P inf → R = inf.
    - py = 0 → R = inf.
  - Any special case goes straight to DONE.
- **General path**, all arithmetic mod p. Modular add/sub is combinational at step boundaries; each multiply uses the `mod_mul` sub-module.
  - NUM:
    - Double: num = 3·px² + a, den = 2·py.
    - Add: num = qy − py, den = qx − px.
    - Exactly one multiply slot in both modes; add mode multiplies num by 1.
  - INV: inv = den^(p−2) by MSB-first square-and-multiply over all W exponent bits. Exactly 2W multiply slots: the square is always done, the multiply is always done, and its result is kept only when the exponent bit is 1.
  - LAM: λ = num·inv (1 slot).
  - RX: rx = λ² − px − qx, with qx := px in double mode (1 slot).
  - RY: ry = λ·(px − rx) − py (1 slot).
- Total: 2W+4 multiply slots; each slot is W+1 cycles (1 load + W shift-add/reduce iterations).

## Timing

- Cycle 0: `i_start`=1 while IDLE is accepted. `o_busy` rises in cycle 1 and stays high until DONE.
- `i_start` while busy or in DONE is ignored, with no queueing.
- Special case: `o_done`=1 in cycle 2.
- General case: `o_done`=1 in cycle 2 + (2W+4)(W+1), which is 62 for W=4.
- Outputs update registered in the DONE cycle and hold until the next DONE or reset.
- Back-to-back operation: a new start is accepted the cycle after DONE.
- Reset values: `o_rx`=0, `o_ry`=0, `o_r_inf`=0, `o_busy`=0, `o_done`=0; state IDLE.
- Reset mid-operation: abort immediately, with no `o_done` pulse. The next start behaves as after power-up.

## Configuration

- `ECC_PU_CONST_TIME_EN`
  - Defined: special cases compute the general path as dummy work and select the special result in DONE, so `o_done` always occurs at cycle 2 + (2W+4)(W+1). Constant time regardless of operands.
  - Undefined: special cases finish at cycle 2 as described above.

## Structure

- `ecc_pkg` holds:
  - state enum;
  - default `W`;
  - function computing general latency from W;
  - mode encoding constants.
- Sub-module `mod_mul`:
  - interleaved shift-add multiplier with per-step conditional subtraction of p;
  - interface: start/done handshake, W+1 cycles, operands < p, result < p.
- Top holds the FSM, operand muxing into `mod_mul`, modular add/sub, and output registers.

## Test plan

Curve: p=11, a=1, y² = x³ + x + 6; P=(2,7).

1. Reset held 3 cycles, then released → all outputs 0, `o_busy`=0; no `o_done` for 100 cycles without start.
2. Double, P=(2,7) → `o_done` at cycle 62, R=(5,2), `o_r_inf`=0; `o_busy` high cycles 1–61.
3. Add, (2,7)+(5,2) → R=(8,3) at cycle 62. Add, (2,7)+(2,7) → R=(5,2) via the double path.
4. Add, (2,7)+(2,4) → `o_r_inf`=1, R=(0,0), `o_done` at cycle 2 (cycle 62 with `ECC_PU_CONST_TIME_EN`). Double with py=0 → inf.
5. `i_p_inf`=1, Q=(5,2), add mode → R=(5,2) at cycle 2. A second `i_start` at cycle 10 of a general op → ignored, single `o_done`.
6. `i_rst` pulsed at cycle 30 of a double → no `o_done`, `o_busy`=0 next cycle. Restart with double (2,7) → (5,2) at cycle 62.
